pe_tile_sequencer: RTL and testbench

- Sequences one tile of MAC work through the precision-configurable PE chain (16-bit mode, or dual-lane 8-bit mode with two 24-bit accumulators packed in a 48-bit word).
- Accepts a tile command, issues activation/weight buffer reads, and drives the PE mode bit and accumulator-clear select. It then flags each finished output word to the writeback stage.
- Sits between the instruction decoder and the PE array plus its operand buffers.

---
 rtl/pe_tile_sequencer_pkg.sv | 22 ++
 rtl/pe_tile_sequencer_delay_line.sv | 29 ++
 rtl/pe_tile_sequencer.sv | 179 +++++++++++++++++
 tb/tb_pe_tile_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_tile_sequencer_pkg.sv
// Shared types and constants for the PE tile sequencer.
// Covers the FSM encoding, the mode constants and the delay-line beat.
package pe_tile_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD,
    DRAIN
  } state_e;

  localparam logic MODE_16B = 1'b0;
  localparam logic MODE_8B  = 1'b1;
  localparam int   LANES_8B = 2;
  localparam int   PE_LAT   = 1;

  typedef struct packed {
    logic valid;
    logic first;
  } beat_t;

endpackage

// File: rtl/pe_tile_sequencer_delay_line.sv
// Fixed-depth shift register that aligns issue beats with buffer read data.
// A synchronous clear empties it when a tile is abandoned.
module seq_delay_line
  import pe_tile_sequencer_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  i_clr,
  input  beat_t i_beat,
  output beat_t o_beat
);

  beat_t r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++)
        r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_beat;
      for (int i = 1; i < DEPTH; i++)
        r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_beat = r_sr[DEPTH-1];

endmodule

// File: rtl/pe_tile_sequencer.sv
// Walks one tile of MAC work through the PE chain.
// It issues operand reads, aligns clear/valid with read data and flags each output word.
module pe_tile_sequencer
  import pe_tile_sequencer_pkg::*;
#(
  parameter int K_W    = 10,
  parameter int M_W    = 10,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode_8bit,
  input  logic [K_W-1:0]    cmd_k_m1,
  input  logic [M_W-1:0]    cmd_m_m1,
  input  logic [ADDR_W-1:0] cmd_act_base,
  input  logic [ADDR_W-1:0] cmd_wgt_base,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              pe_choose_8bit,
  output logic              pe_acc_clear,
  output logic              pe_in_valid,
  output logic              out_valid,
  output logic [1:0]        out_lane_mask,
  output logic [M_W-1:0]    out_idx,
  output logic              busy,
  output logic              done
);

  state_e r_state;
  state_e w_next;

  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    r_k_m1;
  logic [M_W-1:0]    r_p;
  logic [M_W-1:0]    r_p_m1;
  logic [M_W-1:0]    r_oidx;
  logic [ADDR_W-1:0] r_pbase;
  logic [ADDR_W-1:0] r_wbase;
  logic              r_mode;
  logic              r_m_odd;
  logic              r_pv_q;

  logic              w_rd;
  logic              w_rdy;
  logic              w_accept;
  logic              w_k_last;
  logic              w_p_last;
  logic              w_drain_end;
  logic              w_last_out;
  logic              w_ov;
  logic [ADDR_W-1:0] w_kfull;
  beat_t             w_dl_in;
  beat_t             w_dl_out;

  assign w_accept    = cmd_valid & w_rdy;
  assign w_k_last    = (r_k == r_k_m1);
  assign w_p_last    = (r_p == r_p_m1);
  assign w_drain_end = (r_k == K_W'(RD_LAT));
  assign w_kfull     = ADDR_W'(r_k_m1) + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_rdy  = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (cmd_valid) w_next = ISSUE;
      end
      ISSUE: begin
        w_rd = 1'b1;
        if (w_k_last) begin
          if (w_p_last)        w_next = DRAIN;
          else if (!out_ready) w_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) w_next = ISSUE;
      end
      DRAIN: begin
        if (w_drain_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_k doubles as the drain counter once the last pass is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k     <= '0;
      r_k_m1  <= '0;
      r_p     <= '0;
      r_p_m1  <= '0;
      r_oidx  <= '0;
      r_pbase <= '0;
      r_wbase <= '0;
      r_mode  <= MODE_16B;
      r_m_odd <= 1'b0;
      r_pv_q  <= 1'b0;
    end else begin
      r_pv_q <= w_dl_out.valid;
      if (w_ov) r_oidx <= r_oidx + M_W'(1);
      if (w_accept) begin
        r_mode  <= cmd_mode_8bit;
        r_k_m1  <= cmd_k_m1;
        r_p_m1  <= (cmd_mode_8bit == MODE_8B)
                 ? cmd_m_m1 / M_W'(LANES_8B)
                 : cmd_m_m1;
        r_m_odd <= ~cmd_m_m1[0];
        r_pbase <= cmd_act_base;
        r_wbase <= cmd_wgt_base;
        r_k     <= '0;
        r_p     <= '0;
        r_oidx  <= '0;
      end else if (r_state == ISSUE) begin
        if (w_k_last) begin
          r_k <= '0;
          if (!w_p_last) begin
            r_p     <= r_p + M_W'(1);
            r_pbase <= r_pbase + w_kfull;
          end
        end else begin
          r_k <= r_k + K_W'(1);
        end
      end else if (r_state == DRAIN) begin
        r_k <= r_k + K_W'(1);
      end
    end
  end

  assign w_dl_in.valid = w_rd;
  assign w_dl_in.first = w_rd & (r_k == '0);

  seq_delay_line #(
    .DEPTH (RD_LAT)
  ) u_dl (
    .clk    (clk),
    .i_clr  (reset),
    .i_beat (w_dl_in),
    .o_beat (w_dl_out)
  );

  // a pass ends when the beat after its last one is idle or opens a new pass
  assign w_ov       = r_pv_q & (~w_dl_out.valid | w_dl_out.first);
  assign w_last_out = (r_oidx == r_p_m1);

  assign cmd_ready      = w_rdy;
  assign busy           = (r_state != IDLE);
  assign rd_en          = w_rd;
  assign act_addr       = r_pbase + ADDR_W'(r_k);
  assign wgt_addr       = r_wbase + ADDR_W'(r_k);
  assign pe_choose_8bit = r_mode;
  assign pe_in_valid    = w_dl_out.valid;
  assign pe_acc_clear   = w_dl_out.valid & w_dl_out.first;
  assign out_valid      = w_ov;
  assign out_idx        = r_oidx;
  assign done           = w_ov & w_last_out;

  always_comb begin
    out_lane_mask = 2'b00;
    if (w_ov) begin
      if (r_mode == MODE_8B && !(w_last_out && r_m_odd))
        out_lane_mask = 2'b11;
      else
        out_lane_mask = 2'b01;
    end
  end

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Directed bench for pe_tile_sequencer.
// Instance A uses RD_LAT=1 and instance B uses RD_LAT=3.
module tb_pe_tile_sequencer;

  localparam int NC = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_mode_8bit = 1'b0;
  logic [9:0]  cmd_k_m1 = '0;
  logic [9:0]  cmd_m_m1 = '0;
  logic [11:0] cmd_act_base = '0;
  logic [11:0] cmd_wgt_base = '0;
  logic        out_ready = 1'b1;

  logic        a_rdy, a_rd, a_sel, a_clr, a_piv;
  logic        a_ov, a_busy, a_done;
  logic [11:0] a_act, a_wgt;
  logic [1:0]  a_mask;
  logic [9:0]  a_idx;
  logic        b_rdy, b_rd, b_sel, b_clr, b_piv;
  logic        b_ov, b_busy, b_done;
  logic [11:0] b_act, b_wgt;
  logic [1:0]  b_mask;
  logic [9:0]  b_idx;

  logic [NC-1:0] g_rdy, g_busy, g_rd, g_piv;
  logic [NC-1:0] g_clr, g_ov, g_done, g_sel;
  logic [11:0]   g_act  [NC];
  logic [11:0]   g_wgt  [NC];
  logic [1:0]    g_mask [NC];
  logic [9:0]    g_idx  [NC];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  pe_tile_sequencer #(
    .K_W(10), .M_W(10), .ADDR_W(12), .RD_LAT(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(a_rdy),
    .cmd_mode_8bit(cmd_mode_8bit),
    .cmd_k_m1(cmd_k_m1), .cmd_m_m1(cmd_m_m1),
    .cmd_act_base(cmd_act_base),
    .cmd_wgt_base(cmd_wgt_base),
    .out_ready(out_ready), .rd_en(a_rd),
    .act_addr(a_act), .wgt_addr(a_wgt),
    .pe_choose_8bit(a_sel), .pe_acc_clear(a_clr),
    .pe_in_valid(a_piv), .out_valid(a_ov),
    .out_lane_mask(a_mask), .out_idx(a_idx),
    .busy(a_busy), .done(a_done)
  );

  pe_tile_sequencer #(
    .K_W(10), .M_W(10), .ADDR_W(12), .RD_LAT(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(b_rdy),
    .cmd_mode_8bit(cmd_mode_8bit),
    .cmd_k_m1(cmd_k_m1), .cmd_m_m1(cmd_m_m1),
    .cmd_act_base(cmd_act_base),
    .cmd_wgt_base(cmd_wgt_base),
    .out_ready(out_ready), .rd_en(b_rd),
    .act_addr(b_act), .wgt_addr(b_wgt),
    .pe_choose_8bit(b_sel), .pe_acc_clear(b_clr),
    .pe_in_valid(b_piv), .out_valid(b_ov),
    .out_lane_mask(b_mask), .out_idx(b_idx),
    .busy(b_busy), .done(b_done)
  );

  function automatic logic [NC-1:0] rng(input int lo, input int hi);
    logic [NC-1:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // cycle 0 is the accept cycle; outputs logged at each negedge
  task automatic run(
    input bit m8, input logic [9:0] km1, input logic [9:0] mm1,
    input logic [11:0] act, input logic [11:0] wgt,
    input int rlo, input int rhi, input int rstc, input int ignc,
    input bit use_b);
    @(posedge clk); #1;
    cmd_mode_8bit = m8;
    cmd_k_m1 = km1;
    cmd_m_m1 = mm1;
    cmd_act_base = act;
    cmd_wgt_base = wgt;
    cmd_valid = 1'b1;
    out_ready = !(0 >= rlo && 0 <= rhi);
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      g_rdy[c]  = use_b ? b_rdy  : a_rdy;
      g_busy[c] = use_b ? b_busy : a_busy;
      g_rd[c]   = use_b ? b_rd   : a_rd;
      g_piv[c]  = use_b ? b_piv  : a_piv;
      g_clr[c]  = use_b ? b_clr  : a_clr;
      g_ov[c]   = use_b ? b_ov   : a_ov;
      g_done[c] = use_b ? b_done : a_done;
      g_sel[c]  = use_b ? b_sel  : a_sel;
      g_act[c]  = use_b ? b_act  : a_act;
      g_wgt[c]  = use_b ? b_wgt  : a_wgt;
      g_mask[c] = use_b ? b_mask : a_mask;
      g_idx[c]  = use_b ? b_idx  : a_idx;
      @(posedge clk); #1;
      cmd_valid = (c + 1 == ignc);
      cmd_mode_8bit = (c + 1 == ignc) ? !m8 : m8;
      reset = (c + 1 == rstc);
      out_ready = !((c + 1) >= rlo && (c + 1) <= rhi);
    end
    cmd_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic chk_vec(input string nm,
    input logic [NC-1:0] got, input logic [NC-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready got=%b%b exp=11", a_rdy, b_rdy);
    end
    n_chk++;
    if ({a_rd, a_piv, a_clr, a_ov, a_done, a_sel, a_busy}
        !== 7'b0) begin
      n_err++;
      $display("FAIL rst_ctl got=%b exp=0",
        {a_rd, a_piv, a_clr, a_ov, a_done, a_sel, a_busy});
    end
    n_chk++;
    if ({a_act, a_wgt, a_mask, a_idx} !== 36'h0) begin
      n_err++;
      $display("FAIL rst_data got=%h exp=0",
        {a_act, a_wgt, a_mask, a_idx});
    end
  endtask

  task automatic test_16b();
    int oc [5] = '{6, 10, 14, 18, 22};
    run(1'b0, 10'd3, 10'd4, 12'h000, 12'h000, -1, -1, -1, -1, 1'b0);
    chk_vec("t16_ov", g_ov, rng(6,6) | rng(10,10) | rng(14,14)
      | rng(18,18) | rng(22,22));
    chk_vec("t16_done", g_done, rng(22,22));
    chk_vec("t16_rd", g_rd, rng(1,20));
    chk_vec("t16_rdy", g_rdy, rng(0,0) | rng(23,NC-1));
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (g_mask[oc[i]] !== 2'b01 || g_idx[oc[i]] !== 10'(i)) begin
        n_err++;
        $display("FAIL t16_out%0d got=%b/%0d exp=01/%0d",
          i, g_mask[oc[i]], g_idx[oc[i]], i);
      end
    end
  endtask

  task automatic test_8b();
    logic [1:0] em [3] = '{2'b11, 2'b11, 2'b01};
    int oc [3] = '{6, 10, 14};
    run(1'b1, 10'd3, 10'd4, 12'h100, 12'h020, -1, -1, -1, 5, 1'b0);
    chk_vec("t8_ov", g_ov, rng(6,6) | rng(10,10) | rng(14,14));
    chk_vec("t8_done", g_done, rng(14,14));
    chk_vec("t8_rd", g_rd, rng(1,12));
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (g_mask[oc[i]] !== em[i] || g_idx[oc[i]] !== 10'(i)) begin
        n_err++;
        $display("FAIL t8_out%0d got=%b/%0d exp=%b/%0d",
          i, g_mask[oc[i]], g_idx[oc[i]], em[i], i);
      end
    end
    for (int c = 1; c <= 12; c++) begin
      n_chk++;
      if (g_act[c] !== 12'(12'h100 + c - 1) ||
          g_wgt[c] !== 12'(12'h020 + (c - 1) % 4)) begin
        n_err++;
        $display("FAIL t8_addr c%0d got=%h/%h exp=%h/%h", c,
          g_act[c], g_wgt[c], 12'(12'h100 + c - 1),
          12'(12'h020 + (c - 1) % 4));
      end
    end
    n_chk++;
    if (g_sel[10] !== 1'b1) begin
      n_err++;
      $display("FAIL t8_mode_hold got=%b exp=1", g_sel[10]);
    end
  endtask

  task automatic test_hold();
    run(1'b0, 10'd3, 10'd4, 12'h000, 12'h000, 4, 7, -1, -1, 1'b0);
    chk_vec("hold_rd", g_rd, rng(1,4) | rng(9,24));
    chk_vec("hold_piv", g_piv, rng(2,5) | rng(10,25));
    chk_vec("hold_clr", g_clr, rng(2,2) | rng(10,10) | rng(14,14)
      | rng(18,18) | rng(22,22));
    chk_vec("hold_ov", g_ov, rng(6,6) | rng(14,14) | rng(18,18)
      | rng(22,22) | rng(26,26));
    chk_vec("hold_done", g_done, rng(26,26));
  endtask

  task automatic test_k1_lat3();
    run(1'b0, 10'd0, 10'd2, 12'h000, 12'h000, -1, -1, -1, -1, 1'b1);
    chk_vec("k1_rd", g_rd, rng(1,3));
    chk_vec("k1_piv", g_piv, rng(4,6));
    chk_vec("k1_clr", g_clr, rng(4,6));
    chk_vec("k1_ov", g_ov, rng(5,7));
    chk_vec("k1_done", g_done, rng(7,7));
    chk_vec("k1_rdy", g_rdy, rng(0,0) | rng(8,NC-1));
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (g_idx[5 + i] !== 10'(i)) begin
        n_err++;
        $display("FAIL k1_idx%0d got=%0d exp=%0d",
          i, g_idx[5 + i], i);
      end
    end
  endtask

  task automatic test_mid_reset();
    run(1'b1, 10'd3, 10'd4, 12'h100, 12'h000, -1, -1, 8, -1, 1'b0);
    chk_vec("mrst_ov", g_ov, rng(6,6));
    chk_vec("mrst_done", g_done, '0);
    chk_vec("mrst_rdy", g_rdy, rng(0,0) | rng(9,NC-1));
    chk_vec("mrst_busy", g_busy, rng(1,8));
    n_chk++;
    if (g_sel[7] !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_sel7 got=%b exp=1", g_sel[7]);
    end
    run(1'b0, 10'd3, 10'd0, 12'h000, 12'h000, -1, -1, -1, -1, 1'b0);
    chk_vec("mrst_new_sel", g_sel, '0);
    chk_vec("mrst_new_ov", g_ov, rng(6,6));
  endtask

  task automatic test_wrap();
    logic [11:0] ea [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    run(1'b0, 10'd3, 10'd0, 12'hFFE, 12'h000, -1, -1, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (g_act[i + 1] !== ea[i] || g_wgt[i + 1] !== 12'(i)) begin
        n_err++;
        $display("FAIL wrap_addr%0d got=%h/%h exp=%h/%h", i,
          g_act[i + 1], g_wgt[i + 1], ea[i], 12'(i));
      end
    end
    chk_vec("wrap_done", g_done, rng(6,6));
  endtask

  initial begin
    test_reset();
    test_16b();
    test_8b();
    test_hold();
    test_k1_lat3();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
